// File: rtl/pe_beat_arbiter_pkg.sv
// Shared definitions for the PE beat arbiter: FSM state encodings,
// default sizing and a constant log2 helper.
package pe_beat_arbiter_pkg;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_TAG_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Ceiling log2 for sizing ID and pointer fields at elaboration time.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_beat_arbiter_tag_fifo.sv
// pe_tag_fifo: in-order tag queue holding the requester ID of every
// operation issued to the PE and not yet returned.
// A push while full is dropped; the arbiter never pushes when full.
// A pop while empty is ignored; the arbiter flags that case itself.
module pe_tag_fifo
    import pe_beat_arbiter_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              din,
    input  logic                      pop,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count
);

    localparam int PW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array; no reset needed since contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_beat_arbiter.sv
// pe_beat_arbiter: shares one metronome-paced PE among NREQ requesters.
// Each input beat grants one pending requester in round-robin order and
// queues its ID; each output beat pops the oldest ID and pulses done.
// Optional PE_ARB_STATS_EN adds grant and skipped-beat counters.
// Handshake: req is a level held until grant pulses for one cycle, one
// cycle after the sampled beat_in; done pulses one cycle after beat_out.
module pe_beat_arbiter
    import pe_beat_arbiter_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    output logic [NREQ-1:0]               grant,
    output logic                          dev_valid,
    input  logic                          beat_in,
    input  logic                          beat_out,
    output logic [NREQ-1:0]               done,
    output logic                          busy,
    output logic                          tag_full,
    output logic                          err_underflow,
    output arb_state_e                    dbg_state,
    output logic [clog2(TAG_DEPTH):0]     dbg_count
`ifdef PE_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_grants,
    output logic [15:0]                   stat_skips
`endif
);

    localparam int IDW = clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   head;
    logic             push, pop;
    logic             q_full, q_empty;
    logic [NREQ-1:0]  grant_q, done_q;
    logic             dev_valid_q, busy_q, err_q;

    pe_tag_fifo #(
        .W     (IDW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (winner),
        .pop   (pop),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (dbg_count)
    );

    assign pop           = beat_out && !q_empty;
    assign grant         = grant_q;
    assign done          = done_q;
    assign dev_valid     = dev_valid_q;
    assign busy          = busy_q;
    assign tag_full      = q_full;
    assign err_underflow = err_q;
    assign dbg_state     = state_q;

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!found && req[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Next-state, issue decision and round-robin pointer update.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!(|req)) begin
                    state_d = q_empty ? ST_IDLE : ST_DRAIN;
                end else if (beat_in && !q_full) begin
                    push     = 1'b1;
                    rr_ptr_d = winner;
                end
            end
            ST_DRAIN: begin
                if (|req)        state_d = ST_RUN;
                else if (q_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            grant_q     <= '0;
            done_q      <= '0;
            dev_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= push ? (ONE << winner) : '0;
            done_q      <= pop ? (ONE << head) : '0;
            dev_valid_q <= (state_d == ST_RUN);
            busy_q      <= (state_d != ST_IDLE);
            err_q       <= err_q | (beat_out && q_empty);
        end
    end

`ifdef PE_ARB_STATS_EN
    logic [31:0] stat_grants_q;
    logic [15:0] stat_skips_q;

    assign stat_grants = stat_grants_q;
    assign stat_skips  = stat_skips_q;

    // Issued-operation count (wraps) and full-queue skipped beats (saturates).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants_q <= '0;
            stat_skips_q  <= '0;
        end else begin
            if (push) stat_grants_q <= stat_grants_q + 32'd1;
            if (state_q == ST_RUN && beat_in && (|req) && q_full &&
                stat_skips_q != 16'hFFFF) begin
                stat_skips_q <= stat_skips_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_beat_arbiter.sv
// Bench for pe_beat_arbiter (NREQ=4, TAG_DEPTH=8, metronome period 8).
// Table of single-cycle vectors followed by hand-written multi-cycle sequences.
module tb_pe_beat_arbiter;
    import pe_beat_arbiter_pkg::*;

    localparam int NREQ      = 4;
    localparam int TAG_DEPTH = 8;
    localparam int PERIOD    = 8;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0] req = '0;
    logic            beat_in = 1'b0, beat_out = 1'b0;
    logic [NREQ-1:0] grant, done;
    logic            dev_valid, busy, tag_full, err_underflow;
    arb_state_e      dbg_state;
    logic [3:0]      dbg_count;
`ifdef PE_ARB_STATS_EN
    logic [31:0]     stat_grants;
    logic [15:0]     stat_skips;
`endif

    pe_beat_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .grant         (grant),
        .dev_valid     (dev_valid),
        .beat_in       (beat_in),
        .beat_out      (beat_out),
        .done          (done),
        .busy          (busy),
        .tag_full      (tag_full),
        .err_underflow (err_underflow),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
`ifdef PE_ARB_STATS_EN
        ,
        .stat_grants   (stat_grants),
        .stat_skips    (stat_skips)
`endif
    );

    // Scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [NREQ-1:0] exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic       bi, bo;
        logic [3:0] g, d;
        logic       dv, bs, tf, er;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic bi, input logic bo,
                       input logic [3:0] g, input logic [3:0] d,
                       input logic dv, input logic bs, input logic tf, input logic er);
        vec_t v;
        v.req = r; v.bi = bi; v.bo = bo; v.g = g; v.d = d;
        v.dv = dv; v.bs = bs; v.tf = tf; v.er = er;
        vq.push_back(v);
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat(input logic bi, input logic bo);
        beat_in  = bi;
        beat_out = bo;
        step();
        beat_in  = 1'b0;
        beat_out = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; beat_in = 1'b0; beat_out = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        logic [NREQ-1:0] e;

        // Vectors:   req     bi bo  grant    done    dv bs tf er
        add(4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(4'b1111, 0, 0, 4'b0000, 4'b0000, 1, 1, 0, 0);
        add(4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 1, 0, 0);
        add(4'b1111, 0, 0, 4'b0000, 4'b0000, 1, 1, 0, 0);
        add(4'b1111, 1, 0, 4'b0010, 4'b0000, 1, 1, 0, 0);
        add(4'b1111, 1, 0, 4'b0100, 4'b0000, 1, 1, 0, 0);
        add(4'b1111, 1, 1, 4'b1000, 4'b0001, 1, 1, 0, 0);
        add(4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 1, 0, 0);
        add(4'b0000, 0, 1, 4'b0000, 4'b0010, 0, 1, 0, 0);
        add(4'b0000, 1, 1, 4'b0000, 4'b0100, 0, 1, 0, 0);
        add(4'b0100, 0, 0, 4'b0000, 4'b0000, 1, 1, 0, 0);
        add(4'b0100, 1, 0, 4'b0100, 4'b0000, 1, 1, 0, 0);
        add(4'b0000, 0, 1, 4'b0000, 4'b1000, 0, 1, 0, 0);
        add(4'b0000, 0, 1, 4'b0000, 4'b0001, 0, 1, 0, 0);
        add(4'b0000, 0, 1, 4'b0000, 4'b0100, 0, 1, 0, 0);
        add(4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1);
        add(4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);

        do_reset();
        chk("reset.grant", grant, 0);
        chk("reset.done", done, 0);
        chk("reset.busy", busy, 0);
        chk("reset.state", dbg_state, ST_IDLE);

        for (int i = 0; i < vq.size(); i++) begin
            req = vq[i].req; beat_in = vq[i].bi; beat_out = vq[i].bo;
            step();
            chk($sformatf("v%0d.grant", i), grant, vq[i].g);
            chk($sformatf("v%0d.done", i), done, vq[i].d);
            chk($sformatf("v%0d.dev_valid", i), dev_valid, vq[i].dv);
            chk($sformatf("v%0d.busy", i), busy, vq[i].bs);
            chk($sformatf("v%0d.tag_full", i), tag_full, vq[i].tf);
            chk($sformatf("v%0d.err", i), err_underflow, vq[i].er);
        end
        beat_in = 1'b0; beat_out = 1'b0;

        // Asynchronous reset mid-stream, then round-robin over all four.
        req = 4'b1111;
        step();
        beat(1, 0);
        idle(PERIOD - 1);
        #2 rst = 1'b0;
        #1;
        chk("arst.grant", grant, 0);
        chk("arst.done", done, 0);
        chk("arst.dev_valid", dev_valid, 0);
        chk("arst.busy", busy, 0);
        chk("arst.tag_full", tag_full, 0);
        chk("arst.err", err_underflow, 0);
        chk("arst.count", dbg_count, 0);
        step();
        step();
        rst = 1'b1;
        step();
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            beat(1, 0);
            e = exp_q.pop_front();
            chk($sformatf("rr.grant%0d", k), grant, e);
            idle(PERIOD - 1);
        end

        // Fill the tag queue with outputs stalled, then drain in order.
        do_reset();
        req = 4'b0011;
        step();
        for (int k = 0; k < TAG_DEPTH; k++) begin
            beat(1, 0);
            e = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            chk($sformatf("fill.grant%0d", k), grant, e);
            exp_q.push_back(e);
            idle(PERIOD - 1);
        end
        chk("fill.tag_full", tag_full, 1);
        chk("fill.count", dbg_count, 8);
        for (int k = 0; k < 2; k++) begin
            beat(1, 0);
            chk($sformatf("skip.grant%0d", k), grant, 0);
            idle(PERIOD - 1);
        end
`ifdef PE_ARB_STATS_EN
        chk("stats.skips", stat_skips, 2);
        chk("stats.grants", stat_grants, 8);
`endif
        beat(1, 1);
        e = exp_q.pop_front();
        chk("fullboth.done", done, e);
        chk("fullboth.grant", grant, 0);
        chk("fullboth.tag_full", tag_full, 0);
        chk("fullboth.count", dbg_count, 7);
        idle(PERIOD - 1);
        for (int k = 0; k < TAG_DEPTH - 1; k++) begin
            beat(0, 1);
            e = exp_q.pop_front();
            chk($sformatf("drain.done%0d", k), done, e);
            idle(PERIOD - 1);
        end
        chk("drain.err_before", err_underflow, 0);
        beat(0, 1);
        chk("under.done", done, 0);
        chk("under.err", err_underflow, 1);
        idle(3);
        chk("under.sticky", err_underflow, 1);

        // Same-edge issue and return with one entry outstanding.
        do_reset();
        req = 4'b0001;
        step();
        beat(1, 0);
        chk("same.first_grant", grant, 4'b0001);
        idle(PERIOD - 1);
        beat(1, 1);
        chk("same.grant", grant, 4'b0001);
        chk("same.done", done, 4'b0001);
        chk("same.count", dbg_count, 1);
        req = 4'b0000;
        step();
        chk("same.drain_busy", busy, 1);
        chk("same.drain_dev", dev_valid, 0);
        beat(0, 1);
        chk("same.last_done", done, 4'b0001);
        chk("same.empty", dbg_count, 0);
        step();
        chk("same.idle_busy", busy, 0);
        beat(0, 1);
        chk("same.extra_done", done, 0);
        chk("same.extra_err", err_underflow, 1);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
